rb_window_gen: RTL

RB_WINDOW_GEN -- requirements
Module: rb_window_gen

---
 rtl/rb_window_gen.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rb_window_gen.sv
// KxK sliding-window assembler over row-buffer columns; window/win_valid appear 2 cycles after steer_en.
// No backpressure: gaps in steer_en stall the window and counters; start/rst restart.
module rb_window_gen #(
    parameter int PIXEL_W      = 8,
    parameter int RB_DEPTH     = 8,
    parameter int NUM_RB       = 2,
    parameter int IMAGE_HEIGHT = 8,
    parameter int RB_ADDR      = 1
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start,
    input  logic                                           steer_en,
    input  logic [RB_ADDR-1:0]                             steer,
    input  logic [PIXEL_W-1:0]                             pix_in,
    input  logic [NUM_RB*PIXEL_W-1:0]                      rb_data,
    output logic [(NUM_RB+1)*(NUM_RB+1)*PIXEL_W-1:0]       window,
    output logic                                           win_valid,
    output logic [15:0]                                    win_row,
    output logic [15:0]                                    win_col,
    output logic                                           done
);

    localparam int K = NUM_RB + 1;
    localparam int WIN_W = K * K * PIXEL_W;
    localparam logic [15:0] ROW_START = 16'(NUM_RB);
    localparam logic [15:0] COL_LAST  = 16'(RB_DEPTH - 1);
    localparam logic [15:0] ROW_LAST  = 16'(IMAGE_HEIGHT - 1);
    localparam logic [15:0] KM1       = 16'(K - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DONE} state_t;

    state_t               state_q, state_d;
    logic                 en_dly_q, en_dly_d;
    logic [RB_ADDR-1:0]   steer_dly_q, steer_dly_d;
    logic [PIXEL_W-1:0]   pix_dly_q, pix_dly_d;
    logic [15:0]          col_cnt_q, col_cnt_d;
    logic [15:0]          row_cnt_q, row_cnt_d;
    logic [WIN_W-1:0]     win_q, win_d;
    logic                 win_valid_q, win_valid_d;
    logic [15:0]          win_row_q, win_row_d;
    logic [15:0]          win_col_q, win_col_d;
    logic                 done_q, done_d;

    // col[0] is the oldest row: the slot being overwritten is steer, older-to-newer rotates from there
    logic [PIXEL_W-1:0]   col [K];

    always_comb begin
        for (int j = 0; j < NUM_RB; j++) begin
            col[j] = rb_data[((int'(steer_dly_q) + j) % NUM_RB) * PIXEL_W +: PIXEL_W];
        end
        col[NUM_RB] = pix_dly_q;
    end

    always_comb begin
        state_d     = state_q;
        en_dly_d    = steer_en;
        steer_dly_d = steer;
        pix_dly_d   = pix_in;
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        win_d       = win_q;
        win_valid_d = 1'b0;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        done_d      = 1'b0;

        if (start) begin
            state_d   = ST_IDLE;
            win_d     = '0;
            col_cnt_d = '0;
            row_cnt_d = ROW_START;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    win_d     = '0;
                    col_cnt_d = '0;
                    row_cnt_d = ROW_START;
                    state_d   = ST_STREAM;
                end
                ST_STREAM: begin
                    if (en_dly_q) begin
                        for (int r = 0; r < K; r++) begin
                            for (int c = 0; c < K - 1; c++) begin
                                win_d[(r*K + c)*PIXEL_W +: PIXEL_W] = win_q[(r*K + c + 1)*PIXEL_W +: PIXEL_W];
                            end
                            win_d[(r*K + K - 1)*PIXEL_W +: PIXEL_W] = col[r];
                        end
                        if (col_cnt_q >= KM1) begin
                            win_valid_d = 1'b1;
                            win_row_d   = row_cnt_q - KM1;
                            win_col_d   = col_cnt_q - KM1;
                        end
                        if (col_cnt_q == COL_LAST) begin
                            col_cnt_d = '0;
                            row_cnt_d = row_cnt_q + 16'd1;
                            if (row_cnt_q == ROW_LAST) begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            col_cnt_d = col_cnt_q + 16'd1;
                        end
                    end
                end
                ST_DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            en_dly_q    <= 1'b0;
            steer_dly_q <= '0;
            pix_dly_q   <= '0;
            col_cnt_q   <= '0;
            row_cnt_q   <= ROW_START;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_dly_q    <= en_dly_d;
            steer_dly_q <= steer_dly_d;
            pix_dly_q   <= pix_dly_d;
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            done_q      <= done_d;
        end
    end

    assign window    = win_q;
    assign win_valid = win_valid_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign done      = done_q;

endmodule
